square_osc_voice_scheduler: RTL

Time-multiplexes one square-wave oscillator update datapath across VOICES independent voices. On each audio sample tick, it steps every voice's half-period counter and phase, one voice per clock. It then mixes the voice levels into a single 16-bit sample for the discrete audio chain. Per-voice half-period and enable are configured through a simple write port from the core's sound CPU glue.

---
 rtl/square_osc_voice_scheduler_if.sv | 23 ++
 rtl/square_osc_voice_scheduler.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/square_osc_voice_scheduler_if.sv
// Configuration write port and mixed-sample output of the square-wave voice scheduler.
// The sound CPU glue is the master; the scheduler is the slave.
interface square_osc_voice_scheduler_if #(
    parameter int unsigned VOICE_SHIFT = 2,
    parameter int unsigned CNT_WIDTH   = 16
);
    logic                   cfg_we;
    logic [VOICE_SHIFT-1:0] cfg_addr;
    logic [CNT_WIDTH-1:0]   cfg_half_period;
    logic                   cfg_enable;
    logic [15:0]            out;
    logic                   out_valid;

    modport master (
        output cfg_we, cfg_addr, cfg_half_period, cfg_enable,
        input  out, out_valid
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_half_period, cfg_enable,
        output out, out_valid
    );
endinterface

// File: rtl/square_osc_voice_scheduler.sv
// Time-multiplexed square-wave oscillator: one voice is stepped per clk after each
// sample tick, and the voice levels are averaged into a 16-bit unsigned sample.
module square_osc_voice_scheduler #(
    parameter int unsigned VOICE_SHIFT = 2,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          audio_clk_en,
    square_osc_voice_scheduler_if.slave   bus,
    output logic                          busy,
    output logic                          overrun
);
    localparam int unsigned VOICES    = 1 << VOICE_SHIFT;
    localparam int unsigned ACC_WIDTH = 16 + VOICE_SHIFT;

    typedef enum logic {IDLE, UPDATE} state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   hp_q  [VOICES];
    logic                   en_q  [VOICES];
    logic [CNT_WIDTH-1:0]   cnt_q [VOICES];
    logic                   ph_q  [VOICES];
    logic [VOICE_SHIFT-1:0] idx_q, idx_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d, acc_sum;
    logic [15:0]            out_d;
    logic                   out_valid_d, busy_d, overrun_d;
    logic [CNT_WIDTH-1:0]   cnt_step;
    logic                   ph_step;
    logic                   cfg_hit;
    logic [CNT_WIDTH:0]     cnt_inc;
    logic                   last_voice;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    assign last_voice = (idx_q == VOICE_SHIFT'(VOICES - 1));

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (audio_clk_en) state_d = UPDATE;
            UPDATE:  if (last_voice)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Voice step and mix datapath; a config write to the voice in flight silences it this tick
    always_comb begin
        idx_d       = idx_q;
        acc_d       = acc_q;
        out_d       = bus.out;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        overrun_d   = 1'b0;
        cnt_step    = '0;
        ph_step     = 1'b0;
        cfg_hit     = 1'b0;
        acc_sum     = acc_q;
        cnt_inc     = (CNT_WIDTH + 1)'(cnt_q[idx_q]) + (CNT_WIDTH + 1)'(1);
        case (state_q)
            IDLE: begin
                if (audio_clk_en) begin
                    idx_d  = '0;
                    acc_d  = '0;
                    busy_d = 1'b1;
                end
            end
            UPDATE: begin
                overrun_d = audio_clk_en;
                cfg_hit   = bus.cfg_we && (bus.cfg_addr == idx_q);
                if (!en_q[idx_q] || hp_q[idx_q] == '0) begin
                    cnt_step = '0;
                    ph_step  = 1'b0;
                end else if (cnt_inc >= (CNT_WIDTH + 1)'(hp_q[idx_q])) begin
                    cnt_step = '0;
                    ph_step  = ~ph_q[idx_q];
                end else begin
                    cnt_step = cnt_inc[CNT_WIDTH-1:0];
                    ph_step  = ph_q[idx_q];
                end
                acc_sum = acc_q + ((ph_step && !cfg_hit) ? ACC_WIDTH'(16'hFFFF) : ACC_WIDTH'(0));
                if (last_voice) begin
                    out_d       = 16'(acc_sum >> VOICE_SHIFT);
                    out_valid_d = 1'b1;
                    idx_d       = '0;
                end else begin
                    idx_d  = idx_q + VOICE_SHIFT'(1);
                    acc_d  = acc_sum;
                    busy_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q         <= '0;
            acc_q         <= '0;
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            acc_q         <= acc_d;
            bus.out       <= out_d;
            bus.out_valid <= out_valid_d;
            busy          <= busy_d;
            overrun       <= overrun_d;
        end
    end

    // Per-voice state: config writes take priority over stepping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int v = 0; v < VOICES; v++) begin
                hp_q[v]  <= '0;
                en_q[v]  <= 1'b0;
                cnt_q[v] <= '0;
                ph_q[v]  <= 1'b0;
            end
        end else begin
            for (int v = 0; v < VOICES; v++) begin
                if (bus.cfg_we && bus.cfg_addr == VOICE_SHIFT'(v)) begin
                    hp_q[v]  <= bus.cfg_half_period;
                    en_q[v]  <= bus.cfg_enable;
                    cnt_q[v] <= '0;
                    ph_q[v]  <= 1'b0;
                end else if (state_q == UPDATE && idx_q == VOICE_SHIFT'(v)) begin
                    cnt_q[v] <= cnt_step;
                    ph_q[v]  <= ph_step;
                end
            end
        end
    end
endmodule
